// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the operand muxes and the execution ALU.
// The master drives an operation; the slave returns result and handshake.
interface alu_exec_unit_if #(
  parameter int DW = 32
);
  logic          start_i;
  logic [3:0]    ALUCtrl_i;
  logic [DW-1:0] src1_i;
  logic [DW-1:0] src2_i;
  logic [4:0]    shamt_i;
  logic [DW-1:0] result_o;
  logic          zero_o;
  logic          busy_o;
  logic          done_o;

  modport master (
    output start_i, ALUCtrl_i, src1_i,
    output src2_i, shamt_i,
    input  result_o, zero_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, src1_i,
    input  src2_i, shamt_i,
    output result_o, zero_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: registered single-cycle ops plus a
// 32-iteration shift-add multiplier with busy/done handshake.
module alu_exec_unit #(
  parameter int DW       = 32,
  parameter int MUL_ITER = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_exec_unit_if.slave bus
);
  localparam int CW = $clog2(MUL_ITER);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRLV = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ORI  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] acc_sum;
  logic          slt;

  assign slt = $signed(bus.src1_i) < $signed(bus.src2_i);

  always_comb begin
    alu_res = '0;
    unique case (bus.ALUCtrl_i)
      OP_AND:  alu_res = bus.src1_i & bus.src2_i;
      OP_OR:   alu_res = bus.src1_i | bus.src2_i;
      OP_ADD:  alu_res = bus.src1_i + bus.src2_i;
      OP_SUB:  alu_res = bus.src1_i - bus.src2_i;
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, slt};
      OP_SRL:  alu_res = bus.src2_i >> bus.shamt_i;
      OP_SRLV: alu_res = bus.src2_i >> bus.src1_i[4:0];
      OP_LUI:  alu_res = {bus.src2_i[15:0], 16'h0000};
      OP_ORI:  alu_res = bus.src1_i |
                         {16'h0000, bus.src2_i[15:0]};
      default: alu_res = '0;
    endcase
  end

  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            mcand_d  = bus.src1_i;
            mplier_d = bus.src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(MUL_ITER - 1)) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.busy_o   = (state_q == MUL);
  assign bus.done_o   = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against
// an arithmetic reference model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_res = '0;

  alu_exec_unit_if #(.DW(32)) bus ();

  alu_exec_unit #(
    .DW(32),
    .MUL_ITER(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [3:0]  c,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  s
  );
    int sa, sb;
    sa = a;
    sb = b;
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:    return b / (32'd1 << s);
      4'd3:    return b / (32'd1 << (a % 32));
      4'd5:    return (b % 32'h10000) * 32'h10000;
      4'd8:    return a | (b % 32'h10000);
      4'd10:   return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset;
    n_checks++;
    if (bus.result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", bus.result_o);
    end
    n_checks++;
    if (bus.zero_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_zero: got %b want 1", bus.zero_o);
    end
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: busy %b done %b want 0 0",
               bus.busy_o, bus.done_o);
    end
  endtask

  task automatic test_single_cycle;
    logic [3:0]  c[10] = '{4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                           4'd3, 4'd8, 4'd0, 4'd1, 4'd4};
    logic [31:0] a[10] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF,
                           32'd0, 32'd0, 32'h24, 32'hFFFF0000,
                           32'hF0F0F0F0, 32'h0000000F, 32'd0};
    logic [31:0] b[10] = '{32'd1, 32'd5, 32'd1, 32'h1234,
                           32'h80000000, 32'hF0, 32'hABCD1234,
                           32'h0FF00FF0, 32'hF0000000, 32'hDEADBEEF};
    logic [4:0]  s[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31,
                           5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 10; i++) begin
      bus.ALUCtrl_i = c[i];
      bus.src1_i    = a[i];
      bus.src2_i    = b[i];
      bus.shamt_i   = s[i];
      bus.start_i   = 1'b1;
      exp_res = model(c[i], a[i], b[i], s[i]);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.result_o !== exp_res) begin
        n_fail++;
        $display("FAIL single[%0d] result: got %h want %h",
                 i, bus.result_o, exp_res);
      end
      n_checks++;
      if (bus.zero_o !== (exp_res == 32'd0)) begin
        n_fail++;
        $display("FAIL single[%0d] zero: got %b want %b",
                 i, bus.zero_o, exp_res == 32'd0);
      end
      n_checks++;
      if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL single[%0d] hs: done %b busy %b want 1 0",
                 i, bus.done_o, bus.busy_o);
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle done: got %b want 0", bus.done_o);
    end
  endtask

  task automatic test_random_ops(input int n);
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      c = 4'($urandom_range(15));
      if (c == 4'd10) c = 4'd2;
      bus.ALUCtrl_i = c;
      bus.src1_i    = $urandom;
      bus.src2_i    = ($urandom_range(3) == 0) ? bus.src1_i : $urandom;
      bus.shamt_i   = 5'($urandom_range(31));
      bus.start_i   = 1'b1;
      exp_res = model(c, bus.src1_i, bus.src2_i, bus.shamt_i);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.result_o !== exp_res ||
          bus.zero_o !== (exp_res == 32'd0) ||
          bus.done_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rand[%0d] op %h: got %h z%b d%b want %h",
                 i, c, bus.result_o, bus.zero_o, bus.done_o,
                 exp_res);
      end
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_illegal;
    bus.ALUCtrl_i = 4'b1111;
    bus.src1_i    = 32'h12345678;
    bus.src2_i    = 32'h9ABCDEF0;
    bus.start_i   = 1'b1;
    exp_res = 32'd0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    n_checks++;
    if (bus.result_o !== 32'd0 || bus.zero_o !== 1'b1 ||
        bus.done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal: got %h z%b d%b want 0 z1 d1",
               bus.result_o, bus.zero_o, bus.done_o);
    end
  endtask

  task automatic test_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          hold
  );
    logic [31:0] prev;
    prev = exp_res;
    bus.ALUCtrl_i = 4'b1010;
    bus.src1_i    = a;
    bus.src2_i    = b;
    bus.start_i   = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 ||
        bus.result_o !== prev) begin
      n_fail++;
      $display("FAIL mul_start: busy %b done %b res %h want 1 0 %h",
               bus.busy_o, bus.done_o, bus.result_o, prev);
    end
    bus.start_i = hold;
    if (hold) bus.ALUCtrl_i = 4'd2;
    exp_res = a * b;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      bus.src1_i = $urandom;
      bus.src2_i = $urandom;
      @(posedge clk);
      #1;
      n_checks++;
      if (cyc < 32) begin
        if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 ||
            bus.result_o !== prev) begin
          n_fail++;
          $display("FAIL mul_busy c%0d: b%b d%b r%h want 1 0 %h",
                   cyc, bus.busy_o, bus.done_o, bus.result_o, prev);
        end
      end else begin
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b1 ||
            bus.result_o !== exp_res ||
            bus.zero_o !== (exp_res == 32'd0)) begin
          n_fail++;
          $display("FAIL mul_done %h*%h: b%b d%b r%h z%b want %h",
                   a, b, bus.busy_o, bus.done_o, bus.result_o,
                   bus.zero_o, exp_res);
        end
      end
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.done_o !== 1'b0 || bus.result_o !== exp_res) begin
        n_fail++;
        $display("FAIL mul_after: done %b res %h want 0 %h",
                 bus.done_o, bus.result_o, exp_res);
      end
    end
  endtask

  task automatic test_back_to_back;
    test_mul(32'd123457, 32'd98765, 1'b1);
    bus.ALUCtrl_i = 4'd2;
    bus.src1_i    = 32'h00001000;
    bus.src2_i    = 32'h00000234;
    bus.start_i   = 1'b1;
    exp_res = 32'h00001234;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    n_checks++;
    if (bus.result_o !== exp_res || bus.done_o !== 1'b1 ||
        bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL add_after_mul: r%h d%b b%b want %h 1 0",
               bus.result_o, bus.done_o, bus.busy_o, exp_res);
    end
  endtask

  task automatic test_reset_mid_mul;
    bus.ALUCtrl_i = 4'b1010;
    bus.src1_i    = 32'd1000;
    bus.src2_i    = 32'd1000;
    bus.start_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_res = 32'd0;
    n_checks++;
    if (bus.result_o !== 32'd0 || bus.zero_o !== 1'b1 ||
        bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: r%h z%b b%b d%b want 0 1 0 0",
               bus.result_o, bus.zero_o, bus.busy_o, bus.done_o);
    end
    #3;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
          bus.result_o !== 32'd0) begin
        n_fail++;
        $display("FAIL post_reset c%0d: d%b b%b r%h want 0 0 0",
                 cyc, bus.done_o, bus.busy_o, bus.result_o);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = '0;
    bus.src1_i    = '0;
    bus.src2_i    = '0;
    bus.shamt_i   = '0;
    #12;
    test_reset;
    rst_n = 1'b1;
    test_single_cycle;
    test_mul(32'd7, 32'd6, 1'b0);
    test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    test_mul(32'd0, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) test_mul($urandom, $urandom, 1'b0);
    test_back_to_back;
    test_illegal;
    test_random_ops(60);
    test_reset_mid_mul;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU controller and performs the operation on two 32-bit operands.
- Single-cycle operations return a registered result 1 cycle after start.
- mul runs on an iterative shift-add multiplier (32 cycles) with a busy/done handshake, so the pipeline controller can stall.
- Sits between the register-file/immediate muxes and the EX/MEM pipeline register.

Parameters:
- DW, 32, operand and result width.
- MUL_ITER, 32, multiplier iteration count; must equal DW.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  launch operation; sampled on rising edge only while busy_o=0.
- ALUCtrl_i  input  4  operation code (encoding below).
- src1_i  input  DW  operand A (rs).
- src2_i  input  DW  operand B (rt or extended immediate).
- shamt_i  input  5  shift amount for srl.
- result_o  output  DW  registered result.
- zero_o  output  1  registered, 1 when result_o==0.
- busy_o  output  1  1 while multiply in progress.
- done_o  output  1  one-cycle pulse: result_o/zero_o just updated.

Behaviour:
- Reset (rst_i=0, asynchronous): result_o=0, zero_o=1, busy_o=0, done_o=0, state=IDLE, iteration counter=0, accumulator/multiplicand/multiplier regs=0. Applies immediately, including mid-multiply; the aborted op produces no done_o.
- Code map (results modulo 2^32, no overflow flag):
  - 0000 and: src1&src2
  - 0001 or: src1|src2
  - 0010 add/addi: src1+src2
  - 0110 sub/beq: src1-src2
  - 0111 slt/slti: signed src1<src2 → 1, else 0
  - 0100 srl: src2 >> shamt_i, logical
  - 0011 srlv: src2 >> src1[4:0], logical
  - 0101 lui: src2[15:0]<<16
  - 1000 ori: src1 | {16'b0, src2[15:0]}
  - 1010 mul: low 32 bits of src1*src2
  - Any other code: result 0; completes as a single-cycle op.
- States: IDLE, MUL.
- IDLE, start_i=1, code≠1010, at edge E0:
  - result_o and zero_o update; done_o=1 for the following cycle; remain IDLE.
  - Latency 1. Back-to-back starts are allowed every cycle.
- IDLE, start_i=1, code=1010, at E0:
  - Latch multiplicand=src1, multiplier=src2; acc=0; cnt=0; state=MUL; busy_o=1.
  - result_o and zero_o hold their previous values.
- MUL, each edge:
  - If multiplier[0]=1, acc=acc+multiplicand (mod 2^32).
  - Then multiplicand<<=1, multiplier>>=1 (logical), cnt++.
- MUL, edge with cnt==MUL_ITER-1 (edge E32):
  - result_o=final acc, zero_o updated, done_o=1 for 1 cycle, busy_o=0, state=IDLE.
  - Latency 32 cycles from E0 to result.
- start_i while busy_o=1: ignored; operands and code are not captured. The upstream must hold or re-issue.
- start_i on the cycle after mul completion (busy_o=0) is accepted normally.
- done_o is 0 in every cycle not following a completion edge. done_o is never asserted while busy_o=1.
- Operand inputs may change freely during MUL without affecting the result.
- Shift of 0 passes src2 unchanged. srlv uses only src1[4:0] (shift 32 → 0).

Test Plan:
- Reset: drive rst_i=0 mid-mul at iteration 10, release → result_o=0, zero_o=1, busy_o=0, no done_o pulse afterwards.
- Single-cycle ops, back-to-back every cycle:
  - add 0x7FFFFFFF+1 → 0x80000000.
  - sub 5-5 → 0, zero_o=1.
  - slt src1=0xFFFFFFFF, src2=1 → 1.
  - lui src2=0x1234 → 0x12340000.
  - Each has done_o one cycle after its start.
- Shifts:
  - srl src2=0x80000000, shamt=31 → 1.
  - srlv src1=0x24 (uses 4), src2=0xF0 → 0x0F.
  - ori src1=0xFFFF0000, src2=0xABCD1234 → 0xFFFF1234.
- mul 7*6 → result_o=42 exactly 32 cycles after start edge, busy_o high for 32 cycles, single done_o pulse. mul 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
- start_i held high with add codes during mul → ignored, mul result intact; an add issued the cycle after done_o completes with latency 1.
- Illegal code 1111, start → result_o=0, zero_o=1, done_o pulse after 1 cycle.
